// File: rtl/dfb_spi_pkg.sv
// Shared definitions for the DFB SPI data-port master.
package dfb_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } spi_state_t;

  localparam logic        SPI_IDLE_MOSI       = 1'b1;
  localparam logic [7:0]  SPI_RD_FILL         = 8'hFF;
  localparam logic [7:0]  SPI_RX_RESET        = 8'hFF;
  localparam int unsigned DFB_SPI_HALF_PERIOD = 50;

endpackage

// File: rtl/dfb_spi_master_if.sv
// Request/response bus between the DFB register block and the SPI master.
interface dfb_spi_master_if;

  logic       WR_REQ;
  logic       RD_REQ;
  logic [7:0] WR_DATA;
  logic       BUSY;
  logic       DONE;
  logic [7:0] RX_DATA;

  // Register-block side: issues requests, observes status and read data.
  modport master (
    output WR_REQ, RD_REQ, WR_DATA,
    input  BUSY, DONE, RX_DATA
  );

  // SPI engine side.
  modport slave (
    input  WR_REQ, RD_REQ, WR_DATA,
    output BUSY, DONE, RX_DATA
  );

endinterface

// File: rtl/dfb_spi_clkgen.sv
// SCK generator: half-period counter with SCK toggle on each wrap.
// Strobes flag the clock cycle whose closing edge moves SCK up or down.
module dfb_spi_clkgen #(
  parameter int unsigned HALF_PERIOD = 50,
  parameter int unsigned CNT_W       = 8
) (
  input  logic CLKOSC,
  input  logic RST,
  input  logic en,
  output logic sck,
  output logic rise_strobe,
  output logic fall_strobe
);

  logic [CNT_W-1:0] half_cnt;
  logic             wrap;

  assign wrap        = en && (half_cnt == CNT_W'(HALF_PERIOD - 1));
  assign rise_strobe = wrap && !sck;
  assign fall_strobe = wrap && sck;

  // Count half-periods while enabled; idle with counter cleared and SCK low.
  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST) begin
      half_cnt <= '0;
      sck      <= 1'b0;
    end else if (!en) begin
      half_cnt <= '0;
      sck      <= 1'b0;
    end else if (wrap) begin
      half_cnt <= '0;
      sck      <= ~sck;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dfb_spi_master.sv
// Byte-wide SPI master (mode 0, MSB first) for the DFB SPI data port.
module dfb_spi_master
  import dfb_spi_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = DFB_SPI_HALF_PERIOD,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              CLKOSC,
  input  logic              RST,
  dfb_spi_master_if.slave   bus,
  input  logic              CS_IN,
  input  logic              MISO,
  output logic              SCK,
  output logic              MOSI,
  output logic              CS
);

  spi_state_t state;
  logic       shift_en;
  logic       rise_strobe;
  logic       fall_strobe;
  logic       req;
  logic [7:0] load_byte;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [2:0] bit_cnt;
  logic       busy;
  logic       done;
  logic       mosi;
  logic [7:0] rx_data;

  assign shift_en  = (state == ST_SHIFT);
  assign req       = !bus.WR_REQ || !bus.RD_REQ;
  // Write takes priority when both requests arrive together.
  assign load_byte = !bus.WR_REQ ? bus.WR_DATA : SPI_RD_FILL;

  dfb_spi_clkgen #(
    .HALF_PERIOD (HALF_PERIOD),
    .CNT_W       (CNT_W)
  ) u_clkgen (
    .CLKOSC      (CLKOSC),
    .RST         (RST),
    .en          (shift_en),
    .sck         (SCK),
    .rise_strobe (rise_strobe),
    .fall_strobe (fall_strobe)
  );

  // Transfer FSM with shift registers and registered status outputs.
  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      tx_shift <= SPI_RD_FILL;
      rx_shift <= SPI_RX_RESET;
      bit_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mosi     <= SPI_IDLE_MOSI;
      rx_data  <= SPI_RX_RESET;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            busy     <= 1'b1;
            tx_shift <= load_byte;
            mosi     <= load_byte[7];
            bit_cnt  <= '0;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (rise_strobe) begin
            rx_shift <= {rx_shift[6:0], MISO};
          end else if (fall_strobe) begin
            // Terminal count on the 8th falling edge; counter never wraps past it.
            if (bit_cnt == 3'd7) begin
              state   <= ST_FINISH;
              done    <= 1'b1;
              busy    <= 1'b0;
              rx_data <= rx_shift;
              mosi    <= SPI_IDLE_MOSI;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              tx_shift <= {tx_shift[6:0], 1'b1};
              mosi     <= tx_shift[6];
            end
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Chip select is software-framed: a one-cycle registered copy of CS_IN.
  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST) begin
      CS <= 1'b1;
    end else begin
      CS <= CS_IN;
    end
  end

  assign MOSI        = mosi;
  assign bus.BUSY    = busy;
  assign bus.DONE    = done;
  assign bus.RX_DATA = rx_data;

endmodule

// File: tb/tb_dfb_spi_master.sv
// Self-checking bench for dfb_spi_master with a mode-0 SPI device model.
module tb_dfb_spi_master;

  localparam int unsigned HP = 2;

  typedef struct {
    logic       wr_n;
    logic       rd_n;
    logic [7:0] wdata;
    logic [7:0] dev;
    logic [7:0] exp_mosi;
    logic [7:0] exp_rx;
  } vec_t;

  logic CLKOSC = 1'b0;
  logic RST    = 1'b0;
  logic CS_IN  = 1'b1;
  logic MISO;
  logic SCK;
  logic MOSI;
  logic CS;

  dfb_spi_master_if bus ();

  dfb_spi_master #(
    .HALF_PERIOD (HP),
    .CNT_W       (8)
  ) dut (
    .CLKOSC (CLKOSC),
    .RST    (RST),
    .bus    (bus),
    .CS_IN  (CS_IN),
    .MISO   (MISO),
    .SCK    (SCK),
    .MOSI   (MOSI),
    .CS     (CS)
  );

  always #5 CLKOSC = ~CLKOSC;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc_cnt = 0;
  int unsigned e0_cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned rise_cnt = 0;
  logic        mon_clr = 1'b0;
  logic        dev_load = 1'b0;
  logic [7:0]  dev_byte = 8'hFF;
  logic [7:0]  dev_sh;
  logic [7:0]  mosi_cap;

  always @(posedge CLKOSC) cyc_cnt <= cyc_cnt + 1;

  always @(posedge CLKOSC) begin
    if (mon_clr) done_cnt <= 0;
    else if (bus.DONE === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Mode-0 device: presents MSB first, advances on each falling SCK.
  always @(negedge SCK or posedge dev_load) begin
    if (dev_load) dev_sh <= dev_byte;
    else          dev_sh <= {dev_sh[6:0], 1'b1};
  end
  assign MISO = dev_sh[7];

  // Record MOSI as seen by the device on each rising SCK.
  always @(posedge SCK or posedge dev_load) begin
    if (dev_load) begin
      mosi_cap <= '0;
      rise_cnt <= 0;
    end else begin
      mosi_cap <= {mosi_cap[6:0], MOSI};
      rise_cnt <= rise_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic start_xfer(input vec_t v);
    @(negedge CLKOSC);
    mon_clr     = 1'b1;
    dev_byte    = v.dev;
    dev_load    = 1'b1;
    #1 dev_load = 1'b0;
    bus.WR_DATA = v.wdata;
    bus.WR_REQ  = v.wr_n;
    bus.RD_REQ  = v.rd_n;
    @(posedge CLKOSC);
    #1;
    e0_cyc      = cyc_cnt;
    bus.WR_REQ  = 1'b1;
    bus.RD_REQ  = 1'b1;
    bus.WR_DATA = ~v.wdata;
    mon_clr     = 1'b0;
    chk("busy_after_accept", bus.BUSY, 1);
  endtask

  task automatic finish_xfer(input vec_t v);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge CLKOSC);
      #1;
      if (bus.DONE === 1'b1) got = 1'b1;
    end
    chk("done_seen", got, 1);
    chk("done_latency", cyc_cnt - e0_cyc, 16 * HP);
    chk("busy_at_done", bus.BUSY, 0);
    chk("mosi_at_done", MOSI, 1);
    chk("rx_data", bus.RX_DATA, v.exp_rx);
    chk("mosi_bits", mosi_cap, v.exp_mosi);
    chk("sck_rises", rise_cnt, 8);
    @(posedge CLKOSC);
    #1;
    chk("done_one_cycle", bus.DONE, 0);
    chk("done_count", done_cnt, 1);
  endtask

  task automatic run_xfer(input vec_t v);
    start_xfer(v);
    finish_xfer(v);
  endtask

  vec_t vecs[6];
  vec_t v_ign;
  vec_t v_rst;
  vec_t v_55;

  initial begin
    int unsigned bad;
    vecs[0] = '{1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{1'b1, 1'b0, 8'h5A, 8'h81, 8'hFF, 8'h81};
    vecs[2] = '{1'b0, 1'b0, 8'h12, 8'h5A, 8'h12, 8'h5A};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[4] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 8'h80, 8'h01, 8'h80, 8'h01};
    v_ign   = '{1'b0, 1'b1, 8'h3C, 8'hC3, 8'h3C, 8'hC3};
    v_rst   = '{1'b0, 1'b1, 8'hC3, 8'h96, 8'hC3, 8'h96};
    v_55    = '{1'b0, 1'b1, 8'h55, 8'hAA, 8'h55, 8'hAA};

    bus.WR_REQ  = 1'b1;
    bus.RD_REQ  = 1'b1;
    bus.WR_DATA = 8'h00;
    dev_load    = 1'b1;
    #1 dev_load = 1'b0;

    // Reset values
    repeat (3) @(posedge CLKOSC);
    #1;
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_done", bus.DONE, 0);
    chk("rst_rx", bus.RX_DATA, 8'hFF);
    chk("rst_sck", SCK, 0);
    chk("rst_mosi", MOSI, 1);
    chk("rst_cs", CS, 1);

    // Idle with no requests
    @(negedge CLKOSC);
    RST = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLKOSC);
      #1;
      if (SCK !== 1'b0 || MOSI !== 1'b1 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);
    chk("idle_rx", bus.RX_DATA, 8'hFF);

    // Table-driven transfers
    for (int i = 0; i < 6; i++) run_xfer(vecs[i]);

    // Second request mid-transfer is ignored
    start_xfer(v_ign);
    repeat (10) @(posedge CLKOSC);
    @(negedge CLKOSC);
    bus.WR_REQ  = 1'b0;
    bus.WR_DATA = 8'h00;
    @(negedge CLKOSC);
    bus.WR_REQ  = 1'b1;
    finish_xfer(v_ign);
    repeat (40) @(posedge CLKOSC);
    #1;
    chk("no_second_done", done_cnt, 1);
    chk("no_second_busy", bus.BUSY, 0);

    // Asynchronous reset during the 4th bit (SCK high, MOSI=0)
    start_xfer(v_rst);
    repeat (14) @(posedge CLKOSC);
    #2;
    chk("pre_rst_sck", SCK, 1);
    RST = 1'b0;
    #1;
    chk("arst_busy", bus.BUSY, 0);
    chk("arst_sck", SCK, 0);
    chk("arst_mosi", MOSI, 1);
    chk("arst_rx", bus.RX_DATA, 8'hFF);
    chk("arst_done", bus.DONE, 0);
    chk("arst_cs", CS, 1);
    @(negedge CLKOSC);
    RST = 1'b1;
    repeat (60) @(posedge CLKOSC);
    #1;
    chk("arst_no_done", done_cnt, 0);
    chk("arst_idle_busy", bus.BUSY, 0);
    run_xfer(v_55);

    // CS follows CS_IN by one cycle, outside a transfer
    @(posedge CLKOSC);
    #1 CS_IN = 1'b0;
    #1 chk("cs_hold", CS, 1);
    @(posedge CLKOSC);
    #1 chk("cs_fall", CS, 0);
    CS_IN = 1'b1;
    #1 chk("cs_hold_low", CS, 0);
    @(posedge CLKOSC);
    #1 chk("cs_rise", CS, 1);

    // CS toggling during a transfer leaves SCK/MOSI timing intact
    fork
      run_xfer(vecs[0]);
      begin
        repeat (7) @(posedge CLKOSC);
        #2 CS_IN = 1'b0;
        #1 chk("cs_xfer_hold", CS, 1);
        @(posedge CLKOSC);
        #2 chk("cs_xfer_fall", CS, 0);
        repeat (5) @(posedge CLKOSC);
        #2 CS_IN = 1'b1;
        @(posedge CLKOSC);
        #2 chk("cs_xfer_rise", CS, 1);
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
